// File: rtl/sim_memory_model.sv
`default_nettype none
// ============================================================================
// Module      : sim_memory_model
// Description : Single-port, word-addressed behavioural memory that stands in
//               for main memory behind the core's memory interface. One
//               command per clock: either a write or a registered read of one
//               full DATA_WIDTH word. Byte addresses are decoded relative to
//               BASE_ADDR. The low address bits inside a word are ignored.
//               Anything outside [BASE_ADDR, BASE_ADDR+MEM_DEPTH) reads as
//               zero and is ignored on write.
// Ports       :
//   clk_i      in   1           clock, rising edge
//   rst_i      in   1           asynchronous active-high reset
//   cmd_addr   in   ADDR_WIDTH  byte address of the command
//   cmd_valid  in   1           command present this cycle
//   wr_enable  in   1           1 = write, 0 = read (when cmd_valid)
//   wr_data    in   DATA_WIDTH  write data
//   rd_data    out  DATA_WIDTH  registered read data (1-cycle latency)
// Revision    : 1.0 - initial release
// ============================================================================
module sim_memory_model #(
    parameter logic [31:0] BASE_ADDR  = 32'h4000_0000,
    parameter int          MEM_DEPTH  = 4096,
    parameter int          DATA_WIDTH = 256,
    parameter int          ADDR_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic                  cmd_valid,
    input  logic                  wr_enable,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic [DATA_WIDTH-1:0] rd_data
);

    localparam int c_WORD_BYTES = DATA_WIDTH / 8;
    localparam int c_NUM_WORDS  = MEM_DEPTH / c_WORD_BYTES;
    localparam int c_OFF_LSB    = $clog2(c_WORD_BYTES);
    localparam int c_IDX_W      = (c_NUM_WORDS > 1) ? $clog2(c_NUM_WORDS) : 1;

    localparam logic [ADDR_WIDTH-1:0] c_BASE  = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [ADDR_WIDTH-1:0] c_DEPTH = ADDR_WIDTH'(MEM_DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [c_NUM_WORDS];
    logic [DATA_WIDTH-1:0] r_rd_data;

    logic [ADDR_WIDTH-1:0] w_offset;
    logic                  w_in_range;
    logic [c_IDX_W-1:0]    w_index;
    logic                  w_do_write;
    logic                  w_do_read;
    logic                  w_unused_offset_bits;

    // The subtraction wraps for addresses below the base, so the explicit
    // lower-bound compare is what keeps those out of range.
    assign w_offset   = cmd_addr - c_BASE;
    assign w_in_range = (cmd_addr >= c_BASE) && (w_offset < c_DEPTH);

    // Byte-within-word bits are dropped: unaligned addresses hit the
    // containing word. Upper bits are zero whenever w_in_range is set.
    assign w_index = w_offset[c_OFF_LSB +: c_IDX_W];

    // Bits outside the index field carry no information for the array.
    assign w_unused_offset_bits = ^w_offset;

    assign w_do_write = cmd_valid &  wr_enable & w_in_range;
    assign w_do_read  = cmd_valid & ~wr_enable;

    // Storage has no reset: contents survive rst_i. Commands arriving while
    // rst_i is high are still suppressed so reset never corrupts memory.
    always_ff @(posedge clk_i) begin
        if (!rst_i && w_do_write) begin
            r_mem[w_index] <= wr_data;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rd_data <= '0;
        end else if (w_do_read) begin
            r_rd_data <= w_in_range ? r_mem[w_index] : '0;
        end
    end

    assign rd_data = r_rd_data;

endmodule
`default_nettype wire

// File: tb/tb_sim_memory_model.sv
`default_nettype none
// ============================================================================
// Module      : tb_sim_memory_model
// Description : Directed, self-checking bench for sim_memory_model. Inputs
//               change 1 ns after a rising edge; rd_data is sampled 1 ns
//               after the edge that consumed the read command.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sim_memory_model;

    localparam logic [31:0] c_BASE      = 32'h4000_0000;
    localparam int          c_DEPTH     = 4096;
    localparam int          c_DW        = 256;
    localparam int          c_AW        = 32;
    localparam int          c_WB        = c_DW / 8;
    localparam int          c_NUM_WORDS = c_DEPTH / c_WB;
    localparam logic [c_DW-1:0] c_ONES  = '1;

    logic            clk;
    logic            rst;
    logic [c_AW-1:0] cmd_addr;
    logic            cmd_valid;
    logic            wr_enable;
    logic [c_DW-1:0] wr_data;
    logic [c_DW-1:0] rd_data;

    int n_checks = 0;
    int n_errors = 0;

    sim_memory_model #(
        .BASE_ADDR (c_BASE),
        .MEM_DEPTH (c_DEPTH),
        .DATA_WIDTH(c_DW),
        .ADDR_WIDTH(c_AW)
    ) u_dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .cmd_addr (cmd_addr),
        .cmd_valid(cmd_valid),
        .wr_enable(wr_enable),
        .wr_data  (wr_data),
        .rd_data  (rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [c_DW-1:0] obs,
                         input logic [c_DW-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Present one command for exactly one edge, then return 1 ns after it.
    task automatic issue(input logic v, input logic we, input logic [c_AW-1:0] a,
                         input logic [c_DW-1:0] d);
        cmd_valid = v;
        wr_enable = we;
        cmd_addr  = a;
        wr_data   = d;
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [c_AW-1:0] a, input logic [c_DW-1:0] d);
        issue(1'b1, 1'b1, a, d);
    endtask

    // Reads always drive all-ones on wr_data so a stray write would show.
    task automatic rd(input logic [c_AW-1:0] a);
        issue(1'b1, 1'b0, a, c_ONES);
    endtask

    function automatic logic [c_AW-1:0] waddr(input int w);
        return c_BASE + c_AW'(w * c_WB);
    endfunction

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        wr_enable = 1'b0;
        cmd_addr  = '0;
        wr_data   = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_rd_data", rd_data, '0);
        rst = 1'b0;

        // Last word is in range; give it a known value for later checks.
        wr(waddr(c_NUM_WORDS - 1), c_DW'(32'h00C0_FFEE));

        // Sequential fill, then pipelined readback.
        for (int i = 0; i < 16; i++) wr(waddr(i), c_DW'(i + 1));
        for (int i = 0; i < 16; i++) begin
            rd(waddr(i));
            check($sformatf("fill_rd_%0d", i), rd_data, c_DW'(i + 1));
        end
        check("last_word_rd_pre", rd_data, c_DW'(16));
        rd(waddr(c_NUM_WORDS - 1));
        check("last_word", rd_data, c_DW'(32'h00C0_FFEE));

        // Read with all-ones on wr_data must not write.
        rd(waddr(2));
        rd(waddr(2));
        check("read_no_write", rd_data, c_DW'(3));

        // Asynchronous reset between edges; commands during reset ignored.
        wr(waddr(3), c_DW'(16'hABCD));
        rd(waddr(3));
        check("pre_reset_rd", rd_data, c_DW'(16'hABCD));
        #2;
        rst = 1'b1;
        #1;
        check("async_reset_rd", rd_data, '0);
        wr_enable = 1'b1;
        cmd_valid = 1'b1;
        cmd_addr  = waddr(3);
        wr_data   = c_DW'(16'hDEAD);
        @(posedge clk);
        #1;
        check("reset_hold_rd", rd_data, '0);
        rst = 1'b0;
        rd(waddr(3));
        check("post_reset_rd", rd_data, c_DW'(16'hABCD));

        // Out of range on both sides.
        wr(c_BASE - 32'd32, c_DW'(8'h55));
        wr(c_BASE + 32'(c_DEPTH), c_DW'(8'h55));
        rd(c_BASE - 32'd32);
        check("oor_below_rd", rd_data, '0);
        rd(waddr(0));
        check("oor_word0", rd_data, c_DW'(1));
        rd(c_BASE + 32'(c_DEPTH));
        check("oor_above_rd", rd_data, '0);
        rd(waddr(c_NUM_WORDS - 1));
        check("oor_last_word", rd_data, c_DW'(32'h00C0_FFEE));
        rd(32'h0000_0000);
        check("oor_zero_addr", rd_data, '0);

        // Unaligned write hits the containing word; idle holds rd_data.
        wr(waddr(5) + 32'd7, c_DW'(8'h77));
        rd(waddr(5));
        check("unaligned_rd", rd_data, c_DW'(8'h77));
        for (int k = 0; k < 3; k++) begin
            issue(1'b0, 1'b1, waddr(5), c_ONES);
            check($sformatf("idle_hold_%0d", k), rd_data, c_DW'(8'h77));
        end
        rd(waddr(5));
        check("idle_no_write", rd_data, c_DW'(8'h77));

        // Back-to-back write then read of the same word.
        wr(waddr(9), c_DW'(16'h1234));
        rd(waddr(9));
        check("wr_then_rd", rd_data, c_DW'(16'h1234));
        rd(waddr(8));
        check("neighbour_word", rd_data, c_DW'(9));

        cmd_valid = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
